// File: rtl/oam_dma_ctrl_if.sv
// Bus bundle between the CPU core / system bus mux and the sprite DMA controller.
// The CPU side drives cycle info and read data; the controller drives stall and DMA bus.
interface oam_dma_ctrl_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_mem_rw;
  logic [7:0]  mem_rdata;
  logic        cpu_rdy;
  logic        bus_owner;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata;
  logic        dma_rw;
  logic        busy;

  // master: CPU core plus system bus mux
  modport master (
    output cpu_addr, cpu_wdata, cpu_mem_rw, mem_rdata,
    input  cpu_rdy, bus_owner, dma_addr, dma_wdata, dma_rw, busy
  );

  // slave: the DMA controller
  modport slave (
    input  cpu_addr, cpu_wdata, cpu_mem_rw, mem_rdata,
    output cpu_rdy, bus_owner, dma_addr, dma_wdata, dma_rw, busy
  );
endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA: a CPU write to DMA_REG_ADDR stalls the CPU, copies page {page,00..FF}
// to the OAM data port as 256 read/write pairs, then hands the bus back.
module oam_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input logic         clk,
  input logic         rst,
  oam_dma_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HALT  = 3'd1;
  localparam logic [2:0] S_ALIGN = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_WRITE = 3'd4;

  logic [2:0] state_q, state_d;
  logic       cyc_odd_q;
  logic [7:0] page_q, page_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] data_lat_q, data_lat_d;

  logic trig_wr;
  logic xfer_rd, xfer_wr;

  assign trig_wr = !bus.cpu_mem_rw && (bus.cpu_addr == DMA_REG_ADDR);

  always_comb begin
    state_d    = state_q;
    page_d     = page_q;
    cnt_d      = cnt_q;
    data_lat_d = data_lat_q;
    case (state_q)
      S_IDLE: begin
        if (trig_wr) begin
          page_d  = bus.cpu_wdata;
          cnt_d   = 8'h00;
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        // A read cycle means the CPU is now parked; pick READ only if the
        // next cycle lands on the even (read) phase.
        if (bus.cpu_mem_rw) begin
          state_d = cyc_odd_q ? S_READ : S_ALIGN;
        end else if (trig_wr) begin
          page_d = bus.cpu_wdata;
        end
      end
      S_ALIGN: state_d = S_READ;
      S_READ: begin
        data_lat_d = bus.mem_rdata;
        state_d    = S_WRITE;
      end
      S_WRITE: begin
        if (cnt_q == 8'hFF) begin
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q + 8'd1;
          state_d = S_READ;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cyc_odd_q  <= 1'b0;
      page_q     <= 8'h00;
      cnt_q      <= 8'h00;
      data_lat_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      cyc_odd_q  <= ~cyc_odd_q;
      page_q     <= page_d;
      cnt_q      <= cnt_d;
      data_lat_q <= data_lat_d;
    end
  end

  assign xfer_rd = (state_q == S_READ);
  assign xfer_wr = (state_q == S_WRITE);

  assign bus.cpu_rdy   = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.bus_owner = xfer_rd | xfer_wr;
  assign bus.dma_rw    = ~xfer_wr;
  assign bus.dma_addr  = xfer_rd ? {page_q, cnt_q} :
                         xfer_wr ? OAM_DATA_ADDR   : 16'h0000;
  assign bus.dma_wdata = xfer_wr ? data_lat_q : 8'h00;

  // Source address is {page,cnt}: the low byte wraps without touching the page.
  a_rd_even: assert property (@(posedge clk) disable iff (rst) xfer_rd |-> !cyc_odd_q);
  a_wr_odd:  assert property (@(posedge clk) disable iff (rst) xfer_wr |-> cyc_odd_q);

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: byte-addressed memory model, negedge bus monitor,
// per-transfer checks of data order, source addresses, stall length and alignment.
module tb_oam_dma_ctrl;
  logic clk;
  logic rst;
  oam_dma_ctrl_if bus();

  oam_dma_ctrl #(.DMA_REG_ADDR(16'h4014), .OAM_DATA_ADDR(16'h2004)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [0:65535];
  assign bus.mem_rdata = mem[bus.bus_owner ? bus.dma_addr : bus.cpu_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // read/write phase as the block should see it
  logic par;
  always @(posedge clk or posedge rst) begin
    if (rst) par <= 1'b0;
    else     par <= ~par;
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // monitor state
  int         low_cnt, hold_cnt, nrd, nwr, rd_bad, dst_bad, pair_err, lowpage_hit;
  logic [15:0] first_rd, last_rd;
  logic       prev_rd;
  logic [7:0] exp_page;
  logic [7:0] wr_data [0:511];

  task automatic clear_stats();
    low_cnt = 0; hold_cnt = 0; nrd = 0; nwr = 0; rd_bad = 0; dst_bad = 0;
    pair_err = 0; lowpage_hit = 0; first_rd = 16'h0; last_rd = 16'h0; prev_rd = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (!bus.cpu_rdy) low_cnt++;
      if (bus.busy && !bus.bus_owner) hold_cnt++;
      if (bus.bus_owner && bus.dma_rw) begin
        if (nrd == 0) first_rd = bus.dma_addr;
        last_rd = bus.dma_addr;
        if (bus.dma_addr != {exp_page, nrd[7:0]}) rd_bad++;
        if (bus.dma_addr[15:8] == 8'h00) lowpage_hit++;
        nrd++;
      end
      if (bus.bus_owner && !bus.dma_rw) begin
        if (bus.dma_addr != 16'h2004) dst_bad++;
        if (!prev_rd) pair_err++;
        if (nwr < 512) wr_data[nwr] = bus.dma_wdata;
        nwr++;
      end else if (prev_rd) begin
        pair_err++;
      end
      prev_rd = bus.bus_owner && bus.dma_rw;
    end
  end

  task automatic cyc(input logic [15:0] a, input logic [7:0] d, input logic rw);
    bus.cpu_addr   = a;
    bus.cpu_wdata  = d;
    bus.cpu_mem_rw = rw;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(16'h8000, 8'h00, 1'b1);
  endtask

  task automatic align_to(input logic p);
    for (int i = 0; i < 4 && par != p; i++) idle();
  endtask

  // CPU held on a read until the controller releases it; optional 4014 write in a WRITE cycle
  task automatic run_until_idle(input string tag, input logic poke);
    logic done;
    logic poked;
    done = 1'b0;
    poked = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (!bus.busy) begin
        done = 1'b1;
        break;
      end
      if (poke && !poked && bus.bus_owner && !bus.dma_rw) begin
        poked = 1'b1;
        cyc(16'h4014, 8'h09, 1'b0);
      end else begin
        idle();
      end
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
  endtask

  task automatic check_xfer(input string tag, input int exp_low, input int exp_hold,
                            input logic [7:0] w0, input logic [7:0] w255);
    int derr;
    derr = 0;
    for (int i = 0; i < 256; i++)
      if (wr_data[i] !== (8'(i) ^ exp_page ^ 8'h58)) derr++;
    chk({tag, "_nwr"},   32'(nwr), 32'd256);
    chk({tag, "_nrd"},   32'(nrd), 32'd256);
    chk({tag, "_data"},  32'(derr), 32'd0);
    chk({tag, "_w0"},    32'(wr_data[0]), 32'(w0));
    chk({tag, "_w255"},  32'(wr_data[255]), 32'(w255));
    chk({tag, "_src"},   32'(rd_bad), 32'd0);
    chk({tag, "_dst"},   32'(dst_bad), 32'd0);
    chk({tag, "_pair"},  32'(pair_err), 32'd0);
    chk({tag, "_first"}, 32'(first_rd), 32'({exp_page, 8'h00}));
    chk({tag, "_last"},  32'(last_rd), 32'({exp_page, 8'hFF}));
    chk({tag, "_stall"}, 32'(low_cnt), 32'(exp_low));
    chk({tag, "_hold"},  32'(hold_cnt), 32'(exp_hold));
    chk({tag, "_rdy"},   32'(bus.cpu_rdy), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int a = 0; a < 65536; a++) begin
      logic [15:0] av;
      av = 16'(a);
      mem[a] = av[7:0] ^ av[15:8] ^ 8'h58;
    end
    exp_page = 8'h00;
    clear_stats();
    bus.cpu_addr = 16'h8000; bus.cpu_wdata = 8'h00; bus.cpu_mem_rw = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdy",   32'(bus.cpu_rdy), 32'd1);
    chk("rst_owner", 32'(bus.bus_owner), 32'd0);
    chk("rst_busy",  32'(bus.busy), 32'd0);
    chk("rst_addr",  32'(bus.dma_addr), 32'd0);
    chk("rst_wdata", 32'(bus.dma_wdata), 32'd0);
    chk("rst_rw",    32'(bus.dma_rw), 32'd1);
    rst = 1'b0;
    idle();

    // basic: HALT lands on odd phase, straight to READ
    align_to(1'b0);
    exp_page = 8'h02; clear_stats();
    cyc(16'h4014, 8'h02, 1'b0);
    chk("basic_rdy_t1", 32'(bus.cpu_rdy), 32'd0);
    run_until_idle("basic", 1'b0);
    check_xfer("basic", 513, 1, 8'h5A, 8'hA5);

    // odd alignment: trigger one phase later forces ALIGN
    align_to(1'b1);
    clear_stats();
    cyc(16'h4014, 8'h02, 1'b0);
    run_until_idle("odd", 1'b0);
    check_xfer("odd", 514, 2, 8'h5A, 8'hA5);

    // page FF, triggered on the first cycle after completion
    exp_page = 8'hFF; clear_stats();
    cyc(16'h4014, 8'hFF, 1'b0);
    chk("ff_busy", 32'(bus.busy), 32'd1);
    run_until_idle("ff", 1'b0);
    check_xfer("ff", 513, 1, 8'hA7, 8'h58);
    chk("ff_lowpage", 32'(lowpage_hit), 32'd0);

    // pending CPU writes during HALT; middle one relatches page 07
    align_to(1'b1);
    exp_page = 8'h07; clear_stats();
    cyc(16'h4014, 8'h03, 1'b0);
    cyc(16'h0010, 8'hAA, 1'b0);
    cyc(16'h4014, 8'h07, 1'b0);
    cyc(16'h0011, 8'hBB, 1'b0);
    run_until_idle("pend", 1'b0);
    check_xfer("pend", 516, 4, 8'h5F, 8'hA0);

    // non-trigger accesses
    cyc(16'h4014, 8'h11, 1'b1);
    chk("nt_rd4014_busy", 32'(bus.busy), 32'd0);
    cyc(16'h4015, 8'h22, 1'b0);
    chk("nt_wr4015_busy", 32'(bus.busy), 32'd0);
    idle();
    chk("nt_idle_busy", 32'(bus.busy), 32'd0);
    align_to(1'b0);
    exp_page = 8'h04; clear_stats();
    cyc(16'h4014, 8'h04, 1'b0);
    run_until_idle("ntw", 1'b1);
    check_xfer("ntw", 513, 1, 8'h5C, 8'hA3);

    // reset in the READ of byte 100, then retrigger from byte 0
    align_to(1'b0);
    exp_page = 8'h03; clear_stats();
    cyc(16'h4014, 8'h03, 1'b0);
    begin
      logic found;
      found = 1'b0;
      for (int i = 0; i < 1000; i++) begin
        if (bus.bus_owner && bus.dma_rw && bus.dma_addr == 16'h0364) begin
          found = 1'b1;
          break;
        end
        idle();
      end
      chk("mid_found", 32'(found), 32'd1);
    end
    rst = 1'b1;
    #1;
    chk("mid_rdy",   32'(bus.cpu_rdy), 32'd1);
    chk("mid_owner", 32'(bus.bus_owner), 32'd0);
    chk("mid_busy",  32'(bus.busy), 32'd0);
    chk("mid_addr",  32'(bus.dma_addr), 32'd0);
    chk("mid_rw",    32'(bus.dma_rw), 32'd1);
    #1;
    rst = 1'b0;
    clear_stats();
    cyc(16'h4014, 8'h03, 1'b0);
    run_until_idle("retrig", 1'b0);
    check_xfer("retrig", 513, 1, 8'h5B, 8'hA4);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
